// File: rtl/tlp_pkg.sv
// Shared constants for the parametrised TLP detector: framing symbols,
// header field positions, TLP type codes, one-hot indices and FSM encoding.
package tlp_pkg;

  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] END = 8'hFD;

  // Bit positions inside fmt = byte0[6:5]
  localparam int FMT_4DW  = 0;
  localparam int FMT_DATA = 1;

  localparam logic [4:0] TYPE_MEM  = 5'b00000;
  localparam logic [4:0] TYPE_IO   = 5'b00010;
  localparam logic [4:0] TYPE_CFG0 = 5'b00100;
  localparam logic [4:0] TYPE_CFG1 = 5'b00101;
  localparam logic [4:0] TYPE_CPL  = 5'b01010;

  localparam int IDX_MRD    = 0;
  localparam int IDX_MWR    = 1;
  localparam int IDX_IORD   = 2;
  localparam int IDX_IOWR   = 3;
  localparam int IDX_CFGRD0 = 4;
  localparam int IDX_CFGWR0 = 5;
  localparam int IDX_CFGRD1 = 6;
  localparam int IDX_CFGWR1 = 7;
  localparam int IDX_CPL    = 8;
  localparam int IDX_CPLD   = 9;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEQ0   = 3'd1,
    S_SEQ1   = 3'd2,
    S_HDR    = 3'd3,
    S_DATA   = 3'd4,
    S_ENDCHK = 3'd5
  } state_t;

endpackage

// File: rtl/tlp_type_decode.sv
// Maps header fmt/type to a one-hot TLP kind; legal is low for unknown
// types and for 4DW headers on anything other than memory requests.
module tlp_type_decode
  import tlp_pkg::*;
(
  input  logic [1:0] fmt,
  input  logic [4:0] type_code,
  output logic [9:0] type_onehot,
  output logic       legal
);

  logic wd;
  assign wd = fmt[FMT_DATA];

  always_comb begin
    type_onehot = '0;
    legal       = 1'b1;
    case (type_code)
      TYPE_MEM:  type_onehot[wd ? IDX_MWR    : IDX_MRD]    = 1'b1;
      TYPE_IO:   type_onehot[wd ? IDX_IOWR   : IDX_IORD]   = 1'b1;
      TYPE_CFG0: type_onehot[wd ? IDX_CFGWR0 : IDX_CFGRD0] = 1'b1;
      TYPE_CFG1: type_onehot[wd ? IDX_CFGWR1 : IDX_CFGRD1] = 1'b1;
      TYPE_CPL:  type_onehot[wd ? IDX_CPLD   : IDX_CPL]    = 1'b1;
      default:   legal = 1'b0;
    endcase
    if (fmt[FMT_4DW] && (type_code != TYPE_MEM)) legal = 1'b0;
    if (!legal) type_onehot = '0;
  end

endmodule

// File: rtl/tlp_detector_param.sv
// Byte-serial TLP framer/decoder: sizes frames from the header, echoes
// payload, and holds each accepted TLP in a one-entry output register.
//
// Output handshake: tlp_valid stays high with all tlp_* fields stable until a
// cycle with tlp_valid && tlp_ready; that cycle consumes the entry, and a new
// frame committing in the same cycle may reload it.
module tlp_detector_param
  import tlp_pkg::*;
#(
  parameter int MAX_PAYLOAD_DW = 8,
  parameter int CNT_W          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       data_in,
  output logic             pld_valid,
  output logic [7:0]       pld_data,
  output logic             pld_last,
  output logic             tlp_valid,
  input  logic             tlp_ready,
  output logic [127:0]     tlp_hdr,
  output logic [11:0]      tlp_seq,
  output logic [10:0]      tlp_len_dw,
  output logic [9:0]       tlp_type,
  output logic [CNT_W-1:0] tlp_count,
  output logic             err_len,
  output logic             err_end,
  output logic             err_type,
  output logic             err_ovf,
  output logic [CNT_W-1:0] err_count,
  output state_t           dbg_state
);

  localparam logic [10:0] MAX_LEN = 11'(MAX_PAYLOAD_DW);

  state_t       state;
  logic [3:0]   hdr_idx;
  logic [127:0] hdr_buf;
  logic [11:0]  seq_r;
  logic [1:0]   fmt_r;
  logic [4:0]   type_r;
  logic [10:0]  len_r;
  logic [12:0]  data_cnt;

  logic [9:0]   type_onehot;
  logic         type_legal;
  logic [3:0]   hdr_last;
  logic [9:0]   len_raw;
  logic [10:0]  len_full;
  logic         data_last;
  logic         can_load;

  tlp_type_decode u_decode (
    .fmt         (fmt_r),
    .type_code   (type_r),
    .type_onehot (type_onehot),
    .legal       (type_legal)
  );

  assign hdr_last  = fmt_r[FMT_4DW] ? 4'd15 : 4'd11;
  // Length field: hdr byte2[1:0] (already buffered) with byte3 arriving now
  assign len_raw   = {hdr_buf[105:104], data_in};
  assign len_full  = (len_raw == 10'd0) ? 11'd1024 : {1'b0, len_raw};
  assign data_last = (data_cnt == ({len_r, 2'b00} - 13'd1));
  assign can_load  = !tlp_valid || tlp_ready;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      hdr_idx    <= '0;
      hdr_buf    <= '0;
      seq_r      <= '0;
      fmt_r      <= '0;
      type_r     <= '0;
      len_r      <= '0;
      data_cnt   <= '0;
      pld_valid  <= 1'b0;
      pld_data   <= '0;
      pld_last   <= 1'b0;
      tlp_valid  <= 1'b0;
      tlp_hdr    <= '0;
      tlp_seq    <= '0;
      tlp_len_dw <= '0;
      tlp_type   <= '0;
      tlp_count  <= '0;
      err_len    <= 1'b0;
      err_end    <= 1'b0;
      err_type   <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      err_len   <= 1'b0;
      err_end   <= 1'b0;
      err_type  <= 1'b0;
      err_ovf   <= 1'b0;
      pld_valid <= 1'b0;
      pld_last  <= 1'b0;
      if (tlp_valid && tlp_ready) tlp_valid <= 1'b0;

      if (in_valid) begin
        case (state)
          S_IDLE: begin
            if (data_in == STP) begin
              state   <= S_SEQ0;
              hdr_buf <= '0;
              hdr_idx <= '0;
              len_r   <= '0;
            end
          end
          S_SEQ0: begin
            seq_r[11:8] <= data_in[3:0];
            state       <= S_SEQ1;
          end
          S_SEQ1: begin
            seq_r[7:0] <= data_in;
            state      <= S_HDR;
          end
          S_HDR: begin
            hdr_buf <= hdr_buf | ({data_in, 120'b0} >> {hdr_idx, 3'b000});
            hdr_idx <= hdr_idx + 4'd1;
            if (hdr_idx == 4'd0) begin
              fmt_r  <= data_in[6:5];
              type_r <= data_in[4:0];
            end
            if (hdr_idx == 4'd3) begin
              if (fmt_r[FMT_DATA] && (len_full > MAX_LEN)) begin
                err_len <= 1'b1;
                state   <= S_IDLE;
              end else begin
                len_r <= fmt_r[FMT_DATA] ? len_full : 11'd0;
              end
            end else if (hdr_idx == hdr_last) begin
              state    <= fmt_r[FMT_DATA] ? S_DATA : S_ENDCHK;
              data_cnt <= '0;
            end
          end
          S_DATA: begin
            pld_valid <= 1'b1;
            pld_data  <= data_in;
            pld_last  <= data_last;
            data_cnt  <= data_cnt + 13'd1;
            if (data_last) state <= S_ENDCHK;
          end
          S_ENDCHK: begin
            state <= S_IDLE;
            // A bad type wins over a bad END so each frame raises one error
            if (!type_legal) begin
              err_type <= 1'b1;
            end else if (data_in != END) begin
              err_end <= 1'b1;
            end else if (can_load) begin
              tlp_valid  <= 1'b1;
              tlp_hdr    <= hdr_buf;
              tlp_seq    <= seq_r;
              tlp_len_dw <= len_r;
              tlp_type   <= type_onehot;
              tlp_count  <= tlp_count + 1'b1;
            end else begin
              err_ovf <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if ((err_len || err_end || err_type || err_ovf) && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_tlp_detector_param.sv
// Bench for tlp_detector_param: a table of frames plus hand-written sequences
// for back-pressure overflow and mid-frame reset, checked by a scoreboard.
module tb_tlp_detector_param;
  import tlp_pkg::*;

  localparam int W = 161;

  typedef enum int {K_OK, K_LEN, K_END, K_TYPE, K_OVF} kind_t;

  typedef struct {
    logic [7:0]  b0;
    logic [9:0]  len;
    logic [11:0] seq;
    logic [7:0]  endb;
    kind_t       kind;
    logic [9:0]  exp_type;
  } vec_t;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [7:0]   data_in;
  logic         pld_valid;
  logic [7:0]   pld_data;
  logic         pld_last;
  logic         tlp_valid;
  logic         tlp_ready;
  logic [127:0] tlp_hdr;
  logic [11:0]  tlp_seq;
  logic [10:0]  tlp_len_dw;
  logic [9:0]   tlp_type;
  logic [3:0]   tlp_count;
  logic         err_len, err_end, err_type, err_ovf;
  logic [3:0]   err_count;
  state_t       dbg_state;

  tlp_detector_param #(.MAX_PAYLOAD_DW(8), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .data_in    (data_in),
    .pld_valid  (pld_valid),
    .pld_data   (pld_data),
    .pld_last   (pld_last),
    .tlp_valid  (tlp_valid),
    .tlp_ready  (tlp_ready),
    .tlp_hdr    (tlp_hdr),
    .tlp_seq    (tlp_seq),
    .tlp_len_dw (tlp_len_dw),
    .tlp_type   (tlp_type),
    .tlp_count  (tlp_count),
    .err_len    (err_len),
    .err_end    (err_end),
    .err_type   (err_type),
    .err_ovf    (err_ovf),
    .err_count  (err_count),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  int e_len   = 0;
  int e_end   = 0;
  int e_type  = 0;
  int e_ovf   = 0;

  logic [W-1:0] exp_q[$];
  logic [8:0]   pld_q[$];
  logic [3:0]   tlp_cnt_m = '0;
  logic [3:0]   err_cnt_m = '0;
  vec_t         vecs[16];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops on each output event
  always @(negedge clk) begin
    if (reset) begin
      if (tlp_valid && tlp_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_tlp: got seq %0h expected none", tlp_seq);
        end else begin
          check("tlp_fields", {tlp_hdr, tlp_seq, tlp_len_dw, tlp_type}, exp_q.pop_front());
        end
      end
      if (pld_valid) begin
        if (pld_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pld: got %0h expected none", pld_data);
        end else begin
          check("pld_byte", {pld_last, pld_data}, pld_q.pop_front());
        end
      end
      e_len  += int'(err_len);
      e_end  += int'(err_end);
      e_type += int'(err_type);
      e_ovf  += int'(err_ovf);
    end
  end

  // Drivers
  task automatic send_byte(input logic [7:0] b);
    data_in  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input vec_t v);
    logic [127:0] hdr;
    logic [7:0]   b;
    int           hlen;
    int           ndw;
    bit           wd;
    wd   = v.b0[6];
    hlen = v.b0[5] ? 16 : 12;
    ndw  = (v.len == 10'd0) ? 1024 : int'(v.len);
    hdr  = '0;
    send_byte(STP);
    send_byte({4'h0, v.seq[11:8]});
    send_byte(v.seq[7:0]);
    for (int i = 0; i < hlen; i++) begin
      case (i)
        0:       b = v.b0;
        1:       b = 8'h00;
        2:       b = {6'b0, v.len[9:8]};
        3:       b = v.len[7:0];
        4:       b = END;
        5:       b = STP;
        default: b = 8'h30 + 8'(i);
      endcase
      hdr[127-8*i -: 8] = b;
      send_byte(b);
      if (i == 3 && v.kind == K_LEN) return;
    end
    if (wd) begin
      for (int i = 0; i < ndw * 4; i++) begin
        b = (i % 4 == 1) ? STP : (i % 4 == 2) ? END : 8'(8'hA0 + i);
        pld_q.push_back({(i == ndw * 4 - 1), b});
        send_byte(b);
      end
    end
    if (v.kind == K_OK) exp_q.push_back({hdr, v.seq, (wd ? 11'(ndw) : 11'd0), v.exp_type});
    send_byte(v.endb);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int l0, d0, t0, o0, h0;
    logic [31:0] exp_err;
    l0 = e_len; d0 = e_end; t0 = e_type; o0 = e_ovf; h0 = hs_cnt;
    send_frame(v);
    idle(3);
    exp_err = {8'(v.kind == K_LEN), 8'(v.kind == K_END), 8'(v.kind == K_TYPE), 8'(v.kind == K_OVF)};
    check({nm, "_errs"}, {8'(e_len - l0), 8'(e_end - d0), 8'(e_type - t0), 8'(e_ovf - o0)}, exp_err);
    check({nm, "_handshake"}, hs_cnt - h0, (v.kind == K_OK) ? 1 : 0);
    if (v.kind == K_OK) tlp_cnt_m = tlp_cnt_m + 4'd1;
    else if (err_cnt_m != 4'hF) err_cnt_m = err_cnt_m + 4'd1;
    check({nm, "_tlp_count"}, tlp_count, tlp_cnt_m);
    check({nm, "_err_count"}, err_count, err_cnt_m);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish before 500us");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t va, vb;
    int   h0, o0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    data_in   = 8'h00;
    tlp_ready = 1'b1;

    //          b0     len     seq     endb  kind    exp_type
    vecs[0]  = '{8'h00, 10'd1, 12'h005, END,  K_OK,   10'h001}; // MRd 3DW
    vecs[1]  = '{8'h40, 10'd2, 12'h006, END,  K_OK,   10'h002}; // MWr 3DW, 2 DW
    vecs[2]  = '{8'h40, 10'd9, 12'h007, END,  K_LEN,  10'h000}; // over max
    vecs[3]  = '{8'h20, 10'd4, 12'h108, END,  K_OK,   10'h001}; // MRd 4DW
    vecs[4]  = '{8'h60, 10'd8, 12'hA09, END,  K_OK,   10'h002}; // MWr 4DW at max
    vecs[5]  = '{8'h02, 10'd1, 12'h00A, END,  K_OK,   10'h004}; // IORd
    vecs[6]  = '{8'h42, 10'd1, 12'h00B, END,  K_OK,   10'h008}; // IOWr
    vecs[7]  = '{8'h04, 10'd1, 12'h00C, END,  K_OK,   10'h010}; // CfgRd0
    vecs[8]  = '{8'h44, 10'd1, 12'h00D, END,  K_OK,   10'h020}; // CfgWr0
    vecs[9]  = '{8'h05, 10'd1, 12'h00E, END,  K_OK,   10'h040}; // CfgRd1
    vecs[10] = '{8'h45, 10'd1, 12'h00F, END,  K_OK,   10'h080}; // CfgWr1
    vecs[11] = '{8'h0A, 10'd1, 12'hF10, END,  K_OK,   10'h100}; // Cpl
    vecs[12] = '{8'h4A, 10'd1, 12'h011, END,  K_OK,   10'h200}; // CplD
    vecs[13] = '{8'h0A, 10'd1, 12'h012, 8'hFA, K_END, 10'h000}; // bad END
    vecs[14] = '{8'h2A, 10'd1, 12'h013, END,  K_TYPE, 10'h000}; // Cpl 4DW
    vecs[15] = '{8'h40, 10'd0, 12'h014, END,  K_LEN,  10'h000}; // Length 0 = 1024

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_fields", {tlp_hdr, tlp_seq, tlp_len_dw, tlp_type}, '0);
    check("reset_misc", {tlp_valid, tlp_count, err_count, pld_valid, pld_data, pld_last,
                         err_len, err_end, err_type, err_ovf, dbg_state}, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Unknown type and IO with a 4DW header
    va = '{8'h1F, 10'd1, 12'h020, END, K_TYPE, 10'h000};
    run_vec(va, "bad_type");
    va = '{8'h22, 10'd1, 12'h021, END, K_TYPE, 10'h000};
    run_vec(va, "io_4dw");

    // Back-pressure: first frame held, second overflows
    tlp_ready = 1'b0;
    va = '{8'h00, 10'd1, 12'h111, END, K_OK,  10'h001};
    vb = '{8'h04, 10'd1, 12'h222, END, K_OVF, 10'h010};
    h0 = hs_cnt;
    o0 = e_ovf;
    send_frame(va);
    @(negedge clk);
    check("valid_latency", tlp_valid, 1'b1);
    tlp_cnt_m = tlp_cnt_m + 4'd1;
    send_frame(vb);
    idle(3);
    check("ovf_pulse", e_ovf - o0, 1);
    check("ovf_tlp_count", tlp_count, tlp_cnt_m);
    err_cnt_m = err_cnt_m + 4'd1;
    check("ovf_err_count", err_count, err_cnt_m);
    check("hold_stable", {tlp_hdr, tlp_seq, tlp_len_dw, tlp_type}, exp_q[0]);
    tlp_ready = 1'b1;
    idle(2);
    check("ovf_handshake", hs_cnt - h0, 1);
    check("valid_cleared", tlp_valid, 1'b0);

    // Mid-frame reset with a full holding register
    tlp_ready = 1'b0;
    send_frame(va);
    idle(1);
    send_byte(STP);
    send_byte(8'h00);
    send_byte(8'h33);
    for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i));
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_fields", {tlp_hdr, tlp_seq, tlp_len_dw, tlp_type}, '0);
    check("midreset_misc", {tlp_valid, tlp_count, err_count, pld_valid, pld_data, pld_last,
                            err_len, err_end, err_type, err_ovf, dbg_state}, '0);
    exp_q.delete();
    pld_q.delete();
    tlp_cnt_m = '0;
    err_cnt_m = '0;
    @(posedge clk);
    #1;
    reset     = 1'b1;
    tlp_ready = 1'b1;
    idle(1);
    va = '{8'h00, 10'd1, 12'h345, END, K_OK, 10'h001};
    run_vec(va, "after_reset");

    check("exp_q_drained", exp_q.size(), 0);
    check("pld_q_drained", pld_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tlp_detector_param.md
Name: tlp_detector_param

Overview:
Parametrised successor to the fixed-length TLP detector. Consumes a byte-serial link stream, frames TLPs between STP (0xFB) and END (0xFD), and sizes each frame from its header: 3DW or 4DW header, with or without payload. Valid frames are decoded into one of ten TLP types and presented through a one-entry valid/ready output register. Malformed frames are dropped and flagged. Sits between the byte-stream deframer and the transaction-layer receive logic.

Parameters:
MAX_PAYLOAD_DW, 8, largest payload accepted in DWords (1..1024); a larger Length raises err_len.
CNT_W, 4, width of tlp_count and err_count.

Ports:
clk  in  1  clock; all logic is on the rising edge.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  data_in carries a link byte this cycle.
data_in  in  8  link byte.
pld_valid  out  1  pld_data is a payload byte of the frame in progress.
pld_data  out  8  payload byte, registered, 1 cycle after capture.
pld_last  out  1  marks the final payload byte.
tlp_valid  out  1  holding register is full.
tlp_ready  in  1  consumer accepts the holding register.
tlp_hdr  out  128  header bytes; byte0 is in [127:120]; for 3DW headers [31:0]=0.
tlp_seq  out  12  sequence number, {seq0[3:0], seq1}.
tlp_len_dw  out  11  payload DWords; 0 when the TLP has no data.
tlp_type  out  10  one-hot {CplD,Cpl,CfgWr1,CfgRd1,CfgWr0,CfgRd0,IOWr,IORd,MWr,MRd}.
tlp_count  out  CNT_W  accepted frames; wraps.
err_len, err_end, err_type, err_ovf  out  1 each  single-cycle error pulses.
err_count  out  CNT_W  total errors; saturates at all-ones.

Behaviour:
- Bytes are examined only when in_valid=1; when in_valid=0 the FSM holds its state.
- States: IDLE, SEQ0, SEQ1, HDR, DATA, ENDCHK.
- IDLE: 0xFB -> SEQ0; every other byte is ignored.
- SEQ0 -> SEQ1 -> HDR.
- HDR captures bytes in order. Byte0 gives fmt = byte0[6:5] and type = byte0[4:0].
  - Header length is 16 bytes if fmt[0]=1, else 12 bytes.
  - With-data is fmt[1]. When set, Length = {hdr2[1:0], hdr3}; 0 means 1024.
  - After byte3, if with-data and Length > MAX_PAYLOAD_DW: pulse err_len on the next cycle, discard the frame, go to IDLE.
  - After the last header byte: go to DATA if with-data, else ENDCHK.
- DATA: Length*4 bytes, each echoed on pld_data/pld_valid; pld_last accompanies the final byte. Then go to ENDCHK.
- Inside a frame, 0xFB and 0xFD are ordinary data and never restart or terminate the frame.
- ENDCHK expects 0xFD. Any other byte: pulse err_end, go to IDLE; that byte is not re-examined as an STP.
- Type decode (fmt[1] is the with-data bit):
  - MRd/MWr: type 00000.
  - IORd/IOWr: type 00010.
  - CfgRd0/CfgWr0: type 00100.
  - CfgRd1/CfgWr1: type 00101.
  - Cpl/CplD: type 01010.
  - A 4DW header is legal only for MRd/MWr.
  - Anything else pulses err_type at ENDCHK, even when END is correct; the frame is dropped.
- Commit on a correct END with a legal type:
  - If the holding register is empty, or tlp_valid&&tlp_ready in that cycle: load it. tlp_valid rises on the cycle after END is sampled; tlp_count increments.
  - Otherwise: pulse err_ovf and drop the frame; tlp_count is unchanged.
- The holding register is stable while tlp_valid=1 && tlp_ready=0. It clears on handshake unless reloaded in the same cycle.
- err_count adds 1 per error pulse. Error pulses are mutually exclusive per cycle.
- Reset (async, any time, including mid-frame):
  - State goes to IDLE; all outputs go to 0 (tlp_hdr, tlp_seq, tlp_len_dw, tlp_type, tlp_count, err_count included).
  - A partial frame is discarded with no error pulse.

Decomposition:
- Package tlp_pkg holds:
  - STP=8'hFB and END=8'hFD.
  - The fmt bit positions and the five 5-bit type codes.
  - The ten one-hot bit indices.
  - The state encoding.
- Sub-module tlp_type_decode (combinational): inputs fmt, type; outputs the one-hot type and a legal flag.

Test Plan:
- MRd 3DW: FB,00,05, header 00,00,00,01 + 8 bytes, FD (16 bytes) -> tlp_valid 1 cycle after FD; tlp_type=10'h001, tlp_seq=12'h005, tlp_len_dw=0, tlp_count=1.
- MWr 3DW, Length=2: FB,00,06, header 40,00,00,02 + 8 bytes, 8 payload bytes, FD (24 bytes) -> 8 pld_valid beats with pld_last on the 8th; tlp_type=10'h002, tlp_len_dw=2.
- MWr with Length=9 (MAX_PAYLOAD_DW=8) -> err_len on the cycle after hdr byte3; no tlp_valid; err_count=1; a following valid frame is accepted.
- Cpl frame ending in 0xFA instead of FD -> err_end; tlp_count unchanged. Cpl frame with 4DW fmt=01 -> err_type.
- tlp_ready=0 with two back-to-back valid frames -> the first is held stable; the second raises err_ovf; tlp_count=1. Then tlp_ready=1 -> one handshake.
- reset asserted at hdr byte 5, then released -> all outputs 0, no error pulse; the next FB-framed MRd frame decodes normally.
